// File: rtl/aes_pkg.sv
// Shared types for the AES S-box arbiter slice: FSM states, lookup owners,
// byte width and a saturating counter helper.
package aes_pkg;

    localparam int AES_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_K = 2'd1,
        ARB_OWN_S = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_K = 1'b0,
        OWN_S = 1'b1
    } sbox_owner_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sbox_tag_pipe.sv
// Tag pipeline travelling alongside the S-box: one {valid, owner} entry per
// latency stage so each result can be routed back to whoever issued it.
module sbox_tag_pipe
    import aes_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        in_valid,
    input  sbox_owner_t in_owner,
    output logic        tail_valid,
    output sbox_owner_t tail_owner,
    output logic        any_valid
);

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] owner_r;

    // Shift tags one stage per cycle; clear drops every in-flight entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            valid_r <= '0;
            owner_r <= '0;
        end else if (clear) begin
            valid_r <= '0;
            owner_r <= '0;
        end else begin
            valid_r[0] <= in_valid;
            owner_r[0] <= in_owner;
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_r[i] <= valid_r[i-1];
                owner_r[i] <= owner_r[i-1];
            end
        end
    end

    assign tail_valid = valid_r[DEPTH-1];
    assign tail_owner = sbox_owner_t'(owner_r[DEPTH-1]);
    assign any_valid  = |valid_r;

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Arbitrates one S-box between key expansion (K) and SubBytes (S), with locked
// bursts and tagged result routing. Define SBOX_ARB_STATS_EN for grant/stall counters.
module aes_sbox_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LAT  = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  k_req,
    input  logic                  k_lock,
    input  logic [AES_BYTE_W-1:0] k_byte,
    output logic                  k_gnt,
    output logic                  k_rvalid,
    output logic [AES_BYTE_W-1:0] k_result,
    input  logic                  s_req,
    input  logic                  s_lock,
    input  logic [AES_BYTE_W-1:0] s_byte,
    output logic                  s_gnt,
    output logic                  s_rvalid,
    output logic [AES_BYTE_W-1:0] s_result,
    output logic                  sbox_valid,
    output logic [AES_BYTE_W-1:0] sbox_byte,
    input  logic [AES_BYTE_W-1:0] sbox_result,
`ifdef SBOX_ARB_STATS_EN
    output logic [15:0]           k_gnt_cnt,
    output logic [15:0]           s_gnt_cnt,
    output logic [15:0]           stall_cnt,
`endif
    output logic                  busy
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    arb_state_t  state_r, state_nx;
    sbox_owner_t last_served_r, last_nx;
    logic [7:0]  burst_cnt_r, burst_nx, burst_inc_s;
    logic        k_gnt_s, s_gnt_s, accept_s, win_lock_s;
    logic        own_lock_s, other_req_s;
    sbox_owner_t win_owner_s;
    logic        tail_valid_s, any_tag_s;
    sbox_owner_t tail_owner_s;

    // Grant selection from registered state; nothing is granted during a flush.
    always_comb begin
        k_gnt_s = 1'b0;
        s_gnt_s = 1'b0;
        if (clear) begin
            k_gnt_s = 1'b0;
            s_gnt_s = 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (k_req && s_req) begin
                        if (last_served_r == OWN_S) begin
                            k_gnt_s = 1'b1;
                        end else begin
                            s_gnt_s = 1'b1;
                        end
                    end else begin
                        k_gnt_s = k_req;
                        s_gnt_s = s_req;
                    end
                end
                ARB_OWN_K: k_gnt_s = k_req;
                ARB_OWN_S: s_gnt_s = s_req;
                default: begin
                    k_gnt_s = 1'b0;
                    s_gnt_s = 1'b0;
                end
            endcase
        end
    end

    assign accept_s    = k_gnt_s | s_gnt_s;
    assign win_owner_s = s_gnt_s ? OWN_S : OWN_K;
    assign win_lock_s  = s_gnt_s ? s_lock : k_lock;
    assign burst_inc_s = burst_cnt_r + 8'd1;

    // Ownership FSM: lock holds the S-box, MAX_BURST forces release when the other side waits.
    always_comb begin
        state_nx    = state_r;
        burst_nx    = burst_cnt_r;
        last_nx     = last_served_r;
        own_lock_s  = (state_r == ARB_OWN_S) ? s_lock : k_lock;
        other_req_s = (state_r == ARB_OWN_S) ? k_req : s_req;
        case (state_r)
            ARB_IDLE: begin
                if (accept_s) begin
                    last_nx = win_owner_s;
                    if (win_lock_s) begin
                        state_nx = s_gnt_s ? ARB_OWN_S : ARB_OWN_K;
                        burst_nx = 8'd1;
                    end else begin
                        state_nx = ARB_IDLE;
                    end
                end else begin
                    state_nx = ARB_IDLE;
                end
            end
            ARB_OWN_K, ARB_OWN_S: begin
                if (accept_s) begin
                    last_nx = win_owner_s;
                end else begin
                    last_nx = last_served_r;
                end
                if (!own_lock_s) begin
                    state_nx = ARB_IDLE;
                    burst_nx = 8'd0;
                end else if (accept_s) begin
                    if (burst_inc_s == MAX_BURST_C) begin
                        burst_nx = 8'd0;
                        if (other_req_s) begin
                            state_nx = ARB_IDLE;
                        end else begin
                            state_nx = state_r;
                        end
                    end else begin
                        burst_nx = burst_inc_s;
                    end
                end else begin
                    burst_nx = burst_cnt_r;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                burst_nx = 8'd0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r       <= ARB_IDLE;
            last_served_r <= OWN_S;
            burst_cnt_r   <= 8'd0;
        end else if (clear) begin
            state_r       <= ARB_IDLE;
            last_served_r <= OWN_S;
            burst_cnt_r   <= 8'd0;
        end else begin
            state_r       <= state_nx;
            last_served_r <= last_nx;
            burst_cnt_r   <= burst_nx;
        end
    end

    assign k_gnt      = k_gnt_s;
    assign s_gnt      = s_gnt_s;
    assign sbox_valid = accept_s;
    assign sbox_byte  = k_gnt_s ? k_byte : (s_gnt_s ? s_byte : '0);

    sbox_tag_pipe #(
        .DEPTH(SBOX_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (clear),
        .in_valid  (accept_s),
        .in_owner  (win_owner_s),
        .tail_valid(tail_valid_s),
        .tail_owner(tail_owner_s),
        .any_valid (any_tag_s)
    );

    // Route the S-box output to the owner of the tail tag; result regs hold between pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k_rvalid <= 1'b0;
            s_rvalid <= 1'b0;
            k_result <= '0;
            s_result <= '0;
        end else if (clear) begin
            k_rvalid <= 1'b0;
            s_rvalid <= 1'b0;
        end else begin
            k_rvalid <= tail_valid_s && (tail_owner_s == OWN_K);
            s_rvalid <= tail_valid_s && (tail_owner_s == OWN_S);
            if (tail_valid_s && (tail_owner_s == OWN_K)) begin
                k_result <= sbox_result;
            end
            if (tail_valid_s && (tail_owner_s == OWN_S)) begin
                s_result <= sbox_result;
            end
        end
    end

    assign busy = (state_r != ARB_IDLE) | any_tag_s;

`ifdef SBOX_ARB_STATS_EN
    logic stall_s;
    assign stall_s = (k_req & ~k_gnt_s) | (s_req & ~s_gnt_s);

    // Saturating accept and held-off-request counters.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            k_gnt_cnt <= 16'd0;
            s_gnt_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else if (clear) begin
            k_gnt_cnt <= 16'd0;
            s_gnt_cnt <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (k_gnt_s) k_gnt_cnt <= sat_inc16(k_gnt_cnt);
            if (s_gnt_s) s_gnt_cnt <= sat_inc16(s_gnt_cnt);
            if (stall_s) stall_cnt <= sat_inc16(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Directed bench for aes_sbox_arbiter: a latency-1 and a latency-3 instance,
// each fed by a behavioural S-box; expected values are hand-computed constants.
module tb_aes_sbox_arbiter;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic       clear1, k_req1, k_lock1, s_req1, s_lock1;
    logic [7:0] k_byte1, s_byte1, k_result1, s_result1, sbox_byte1, sbox_result1;
    logic       k_gnt1, k_rvalid1, s_gnt1, s_rvalid1, sbox_valid1, busy1;

    logic       clear2, k_req2, k_lock2, s_req2, s_lock2;
    logic [7:0] k_byte2, s_byte2, k_result2, s_result2, sbox_byte2;
    logic       k_gnt2, k_rvalid2, s_gnt2, s_rvalid2, sbox_valid2, busy2;
    logic [7:0] sb2_p [0:2];

`ifdef SBOX_ARB_STATS_EN
    logic [15:0] kc1, sc1, st1, kc2, sc2, st2;
`endif

    // First row of the AES S-box: S(0x00)..S(0x0F).
    logic [7:0] row0 [0:15] = '{8'h63, 8'h7C, 8'h77, 8'h7B, 8'hF2, 8'h6B, 8'h6F, 8'hC5,
                                8'h30, 8'h01, 8'h67, 8'h2B, 8'hFE, 8'hD7, 8'hAB, 8'h76};

    int total = 0;
    int bad   = 0;

    aes_sbox_arbiter #(.SBOX_LAT(1), .MAX_BURST(16)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .clear(clear1),
        .k_req(k_req1), .k_lock(k_lock1), .k_byte(k_byte1), .k_gnt(k_gnt1),
        .k_rvalid(k_rvalid1), .k_result(k_result1),
        .s_req(s_req1), .s_lock(s_lock1), .s_byte(s_byte1), .s_gnt(s_gnt1),
        .s_rvalid(s_rvalid1), .s_result(s_result1),
        .sbox_valid(sbox_valid1), .sbox_byte(sbox_byte1), .sbox_result(sbox_result1),
`ifdef SBOX_ARB_STATS_EN
        .k_gnt_cnt(kc1), .s_gnt_cnt(sc1), .stall_cnt(st1),
`endif
        .busy(busy1)
    );

    aes_sbox_arbiter #(.SBOX_LAT(3), .MAX_BURST(16)) u_dut2 (
        .clk(clk), .n_rst(n_rst), .clear(clear2),
        .k_req(k_req2), .k_lock(k_lock2), .k_byte(k_byte2), .k_gnt(k_gnt2),
        .k_rvalid(k_rvalid2), .k_result(k_result2),
        .s_req(s_req2), .s_lock(s_lock2), .s_byte(s_byte2), .s_gnt(s_gnt2),
        .s_rvalid(s_rvalid2), .s_result(s_result2),
        .sbox_valid(sbox_valid2), .sbox_byte(sbox_byte2), .sbox_result(sb2_p[2]),
`ifdef SBOX_ARB_STATS_EN
        .k_gnt_cnt(kc2), .s_gnt_cnt(sc2), .stall_cnt(st2),
`endif
        .busy(busy2)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Behavioural S-boxes: one and three cycles of latency.
    always @(posedge clk) begin
        sbox_result1 <= sbox_f(sbox_byte1);
        sb2_p[0]     <= sbox_f(sbox_byte2);
        sb2_p[1]     <= sb2_p[0];
        sb2_p[2]     <= sb2_p[1];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear1 = 1'b0; k_req1 = 1'b0; k_lock1 = 1'b0; s_req1 = 1'b0; s_lock1 = 1'b0;
        k_byte1 = 8'h00; s_byte1 = 8'h00;
        clear2 = 1'b0; k_req2 = 1'b0; k_lock2 = 1'b0; s_req2 = 1'b0; s_lock2 = 1'b0;
        k_byte2 = 8'h00; s_byte2 = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        // Test 1: reset state
        do_reset();
        #3;
        chk("rst_kgnt", k_gnt1, 1'b0);
        chk("rst_sgnt", s_gnt1, 1'b0);
        chk("rst_krv", k_rvalid1, 1'b0);
        chk("rst_srv", s_rvalid1, 1'b0);
        chk("rst_sbv", sbox_valid1, 1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_kres", k_result1, 8'h00);
        chk("rst_sres", s_result1, 8'h00);
        chk("rst_busy2", busy2, 1'b0);
        nxt();

        // Test 2: single K lookup, latency 2 to rvalid
        k_req1 = 1'b1; k_byte1 = 8'h53;
        #3;
        chk("t2_kgnt", k_gnt1, 1'b1);
        chk("t2_sbv", sbox_valid1, 1'b1);
        chk("t2_sbbyte", sbox_byte1, 8'h53);
        nxt();
        k_req1 = 1'b0;
        #3;
        chk("t2_krv_early", k_rvalid1, 1'b0);
        chk("t2_busy", busy1, 1'b1);
        chk("t2_sbv_off", sbox_valid1, 1'b0);
        nxt();
        #3;
        chk("t2_krv", k_rvalid1, 1'b1);
        chk("t2_kres", k_result1, 8'hED);
        chk("t2_srv", s_rvalid1, 1'b0);
        nxt();
        #3;
        chk("t2_krv_pulse", k_rvalid1, 1'b0);
        chk("t2_kres_hold", k_result1, 8'hED);
        chk("t2_busy_end", busy1, 1'b0);

        // Test 3: both requesting from reset, unlocked -> K,S,K,S...
        do_reset();
        for (int i = 0; i < 8; i++) begin
            k_req1 = (i < 6); s_req1 = (i < 6);
            k_byte1 = 8'(i); s_byte1 = 8'(i);
            #3;
            if (i < 6) begin
                chk("t3_kgnt", k_gnt1, (i % 2 == 0));
                chk("t3_sgnt", s_gnt1, (i % 2 == 1));
                chk("t3_sbbyte", sbox_byte1, 8'(i));
            end
            if (i >= 2) begin
                chk("t3_krv", k_rvalid1, ((i - 2) % 2 == 0));
                chk("t3_srv", s_rvalid1, ((i - 2) % 2 == 1));
                if ((i - 2) % 2 == 0) chk("t3_kres", k_result1, row0[i-2]);
                else                  chk("t3_sres", s_result1, row0[i-2]);
            end
            nxt();
        end

        // Test 4: clear blocks grants, then a 16-lookup locked S burst with K waiting
        clear1 = 1'b1; k_req1 = 1'b1;
        #3;
        chk("t4_clr_kgnt", k_gnt1, 1'b0);
        nxt();
        for (int i = 0; i < 19; i++) begin
            clear1 = 1'b0;
            s_req1 = (i < 16); s_lock1 = (i < 16); s_byte1 = 8'(i);
            k_req1 = (i >= 1 && i <= 16); k_byte1 = 8'h53;
            #3;
            if (i < 16) begin
                chk("t4_sgnt", s_gnt1, 1'b1);
                chk("t4_kstall", k_gnt1, 1'b0);
                chk("t4_sbbyte", sbox_byte1, 8'(i));
            end
            if (i == 16) begin
                chk("t4_kgnt17", k_gnt1, 1'b1);
                chk("t4_kbyte", sbox_byte1, 8'h53);
            end
            if (i >= 2 && i < 18) begin
                chk("t4_srv", s_rvalid1, 1'b1);
                chk("t4_sres", s_result1, row0[i-2]);
            end
            if (i == 18) begin
                chk("t4_krv", k_rvalid1, 1'b1);
                chk("t4_kres", k_result1, 8'hED);
                chk("t4_srv_end", s_rvalid1, 1'b0);
            end
            nxt();
        end
`ifdef SBOX_ARB_STATS_EN
        #3;
        chk("t6_scnt", sc1, 16'd16);
        chk("t6_kcnt", kc1, 16'd1);
        chk("t6_stall", st1, 16'd15);
        nxt();
        clear1 = 1'b1;
        nxt();
        clear1 = 1'b0;
        #3;
        chk("t6_scnt_clr", sc1, 16'd0);
        chk("t6_kcnt_clr", kc1, 16'd0);
        chk("t6_stall_clr", st1, 16'd0);
        nxt();
`endif

        // Test 5: latency-3 instance, clear with two lookups in flight
        k_req2 = 1'b1; k_byte2 = 8'h53;
        #3;
        chk("t5_kgnt0", k_gnt2, 1'b1);
        nxt();
        k_req2 = 1'b0; s_req2 = 1'b1; s_byte2 = 8'h00;
        #3;
        chk("t5_sgnt1", s_gnt2, 1'b1);
        nxt();
        s_req2 = 1'b0; clear2 = 1'b1;
        #3;
        chk("t5_busy_inflight", busy2, 1'b1);
        nxt();
        clear2 = 1'b0; k_req2 = 1'b1; k_byte2 = 8'h01;
        #3;
        chk("t5_busy_cleared", busy2, 1'b0);
        chk("t5_kgnt_after", k_gnt2, 1'b1);
        nxt();
        k_req2 = 1'b0;
        for (int c = 4; c < 9; c++) begin
            #3;
            chk("t5_krv", k_rvalid2, (c == 7));
            chk("t5_srv", s_rvalid2, 1'b0);
            if (c == 7) chk("t5_kres", k_result2, 8'h7C);
            nxt();
        end
        chk("t5_busy_end", busy2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
